mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register. Sits directly downstream of the EX/MEM register and consumes its M-suffixed outputs.
- Performs data-memory loads and stores through a req/ack handshake and stalls the upstream pipeline while an access is outstanding.
- Selects the write-back value and registers the W-stage signals that feed the register file.

Parameters:
- TIMEOUT_CYCLES, 64, ACCESS cycles without dmem_ack before abort. Used only with MEM_TIMEOUT_EN.
- LOAD_SRC, 2'b01, regSrc_muxM encoding meaning "write-back from memory" (marks a load).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Regfile_weM  in  1  register-file write enable from EX/MEM.
- DataMem_weM  in  1  store request from EX/MEM.
- writeRegAddrM  in  5  destination register.
- regSrc_muxM  in  2  write-back select: 00 ALU, 01 memory, 10 jal_targetM, 11 ALU.
- aluOutM  in  32  ALU result; also the memory address.
- writeDataM  in  32  store data.
- jal_targetM  in  32  link value.
- pcM  in  32  instruction PC.
- dmem_req  out  1  memory request, held until ack.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  byte address.
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, valid with ack.
- dmem_ack  in  1  one-cycle completion pulse.
- stallM  out  1  hold EX/MEM and all earlier stages.
- Regfile_weW  out  1  registered write enable.
- writeRegAddrW  out  5  registered destination.
- writeBackDataW  out  32  registered write-back value.
- pcW  out  32  registered PC.
- misalign_errW  out  1  registered one-cycle error flag.
- timeout_errW  out  1  registered one-cycle error flag.

Behaviour:
- Definitions:
  - memop = DataMem_weM | (regSrc_muxM == LOAD_SRC).
  - misaligned = memop & (aluOutM[1:0] != 0).
- FSM states: IDLE, ACCESS.
  - IDLE → ACCESS when memop & !misaligned.
  - ACCESS → IDLE on dmem_ack (or on timeout, if enabled).
- Memory interface:
  - dmem_req = (state == ACCESS).
  - dmem_we, dmem_addr and dmem_wdata are registered on IDLE→ACCESS entry and held stable for the whole of ACCESS.
- Stall (combinational): stallM = (IDLE & memop & !misaligned) | (ACCESS & !dmem_ack). stallM drops in the ack cycle, so EX/MEM advances on the same edge that the result is captured. No operation is ever issued twice.
- W-register updates, every edge:
  - Stall cycles: bubble. Regfile_weW = 0, error flags = 0, other W outputs hold.
  - Non-memory op: 1-cycle pass-through. Regfile_weW = Regfile_weM. writeBackDataW = aluOutM for select 00/11, or jal_targetM for select 10.
  - Load completing on ack: writeBackDataW = dmem_rdata, Regfile_weW = Regfile_weM.
  - Store completing on ack: Regfile_weW = 0.
- Memory-op latency: minimum 2 cycles (IDLE detect cycle + ack in the first ACCESS cycle). Each additional wait cycle adds one.
- Misaligned memop: no request and no stall. Regfile_weW = 0, misalign_errW = 1 for one cycle. The instruction retires as a bubble.
- dmem_ack while in IDLE: ignored.
- Reset value of all outputs: 0, state = IDLE. Asynchronous assertion during ACCESS drops dmem_req immediately and abandons the access; the memory must tolerate this.
- writeRegAddrW = writeRegAddrM and pcW = pcM whenever the W register captures a non-bubble.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - Counter clears on ACCESS entry and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 without ack: FSM → IDLE, stallM = 0 in that cycle, W captures Regfile_weW = 0, writeBackDataW = 0, timeout_errW = 1 for one cycle.
  - If ack and timeout coincide, ack wins.
- Not defined: no counter; ACCESS waits indefinitely; timeout_errW is tied to 0.

Test Plan:
- ALU op, regSrc=00, aluOutM=0x1234, Regfile_weM=1, rd=5 → next edge: Regfile_weW=1, writeRegAddrW=5, writeBackDataW=0x1234; stallM never high.
- Load, addr 0x100, ack after 3 wait cycles with rdata 0xCAFEF00D → stallM high for 4 cycles, dmem_req high for 4 cycles, then W = 0xCAFEF00D, we=1, exactly one request issued.
- Store, addr 0x200, data 0xA5A5A5A5, immediate ack → dmem_we=1, addr/wdata stable while req high; W has Regfile_weW=0; next instruction accepted on the following edge.
- Load, addr 0x102 → no dmem_req, misalign_errW=1 for one cycle, Regfile_weW=0, no stall.
- rst driven low mid-ACCESS → dmem_req, stallM and all W outputs go 0 immediately; after release, state is IDLE and a fresh load completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, a load with no ack → req high for 4 cycles, then timeout_errW=1, Regfile_weW=0, stall released.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB pipeline register with a req/ack data-memory port.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_wb_stage #(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [1:0] LOAD_SRC       = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Regfile_weM,
    input  logic        DataMem_weM,
    input  logic [4:0]  writeRegAddrM,
    input  logic [1:0]  regSrc_muxM,
    input  logic [31:0] aluOutM,
    input  logic [31:0] writeDataM,
    input  logic [31:0] jal_targetM,
    input  logic [31:0] pcM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stallM,
    output logic        Regfile_weW,
    output logic [4:0]  writeRegAddrW,
    output logic [31:0] writeBackDataW,
    output logic [31:0] pcW,
    output logic        misalign_errW,
    output logic        timeout_errW
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state, state_nxt;
    logic   memop, misaligned, issue, ack_hit, timeout_hit;

    assign memop      = DataMem_weM | (regSrc_muxM == LOAD_SRC);
    assign misaligned = memop & (aluOutM[1:0] != 2'b00);
    assign issue      = (state == IDLE) & memop & !misaligned;
    assign ack_hit    = (state == ACCESS) & dmem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] tmo_cnt;

    // Ack in the same cycle as the last allowed wait cycle takes priority.
    assign timeout_hit = (state == ACCESS) & !dmem_ack & (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt      <= '0;
            timeout_errW <= 1'b0;
        end else begin
            timeout_errW <= timeout_hit;
            if (issue)
                tmo_cnt <= '0;
            else if ((state == ACCESS) & !dmem_ack)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_errW = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = ACCESS;
            ACCESS:  if (ack_hit | timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Reset gates the stall so upstream is released the moment reset asserts.
    assign stallM   = rst & (issue | ((state == ACCESS) & !dmem_ack & !timeout_hit));
    assign dmem_req = (state == ACCESS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else if (issue) begin
            dmem_we    <= DataMem_weM;
            dmem_addr  <= aluOutM;
            dmem_wdata <= writeDataM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Regfile_weW    <= 1'b0;
            writeRegAddrW  <= '0;
            writeBackDataW <= '0;
            pcW            <= '0;
            misalign_errW  <= 1'b0;
        end else begin
            Regfile_weW   <= 1'b0;
            misalign_errW <= 1'b0;
            if (state == ACCESS) begin
                if (ack_hit) begin
                    // Stores never write the register file, even if Regfile_weM is set.
                    Regfile_weW   <= Regfile_weM & !dmem_we;
                    writeRegAddrW <= writeRegAddrM;
                    pcW           <= pcM;
                    if (!dmem_we) writeBackDataW <= dmem_rdata;
                end else if (timeout_hit) begin
                    writeBackDataW <= '0;
                end
            end else if (misaligned) begin
                misalign_errW <= 1'b1;
            end else if (!memop) begin
                Regfile_weW    <= Regfile_weM;
                writeRegAddrW  <= writeRegAddrM;
                pcW            <= pcM;
                writeBackDataW <= (regSrc_muxM == 2'b10) ? jal_targetM : aluOutM;
            end
        end
    end

endmodule
